adder_operand_loader: RTL and testbench

Upstream operand-entry stage for the 4-bit ripple adder.
- Captures operand A, then operand B plus carry-in, from the slide switches, one debounced ENTER press per operand.
- Presents the captured operand bundle to the adder in the same bit layout the adder's switch input uses, qualified by a valid/ready handshake.
- Sits between the raw board switches/keys and the adder datapath. Lets a user build operands sequentially instead of needing 9 switches at once.

---
 rtl/adder_operand_loader_pkg.sv | 22 ++
 rtl/adder_operand_loader_key_debounce.sv | 47 ++++
 rtl/adder_operand_loader.sv | 109 ++++++++++
 tb/tb_adder_operand_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the adder operand loader: FSM encoding, op_bus field
// offsets and the default debounce length.
package adder_operand_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        VALID  = 2'b10
    } state_t;

    localparam int A_LSB                   = 0;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    function automatic int b_lsb(input int width);
        return width;
    endfunction

    function automatic int cin_bit(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/adder_operand_loader_key_debounce.sv
// Key conditioning: 2-flop synchroniser, saturating debounce counter and a
// one-cycle press pulse on the accepted 0->1 edge.
module key_debounce
    import adder_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_p0;
    logic             key_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_p0    <= 1'b0;
            key_p1    <= 1'b0;
            cnt       <= '0;
            key_level <= 1'b0;
            key_press <= 1'b0;
        end else begin
            key_p0    <= key_raw;
            key_p1    <= key_p0;
            key_press <= 1'b0;
            // Counter only advances while the synced level disagrees; it stops
            // at CNT_MAX, where the new level is accepted.
            if (key_p1 == key_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_level <= key_p1;
                key_press <= key_p1;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_operand_loader.sv
// Sequential operand entry for the 4-bit ripple adder: A, then B+cin, captured
// on debounced ENTER presses and offered downstream with a valid/ready handshake.
module adder_operand_loader
    import adder_operand_loader_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_cin,
    input  logic             key_enter,
    input  logic             key_clear,
    output logic [2*WIDTH:0] op_bus,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       state_led
);

    localparam int B_LSB   = b_lsb(WIDTH);
    localparam int CIN_BIT = cin_bit(WIDTH);

    logic [WIDTH:0]   sw_p0;
    logic [WIDTH:0]   sw_p1;
    logic             enter_level;
    logic             enter_press;
    logic             clear_level;
    logic             clear_press;
    state_t           state;
    state_t           state_n;
    logic [2*WIDTH:0] bus_n;
    logic             valid_n;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .key_raw   (key_enter),
        .key_level (enter_level),
        .key_press (enter_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .key_raw   (key_clear),
        .key_level (clear_level),
        .key_press (clear_press)
    );

    always_comb begin
        state_n = state;
        bus_n   = op_bus;
        valid_n = op_valid;
        // Clear overrides everything, including a same-cycle enter or handshake.
        if (clear_press) begin
            state_n = LOAD_A;
            bus_n   = '0;
            valid_n = 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (enter_press) begin
                        bus_n[A_LSB +: WIDTH] = sw_p1[WIDTH-1:0];
                        state_n               = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_press) begin
                        bus_n[B_LSB +: WIDTH] = sw_p1[WIDTH-1:0];
                        bus_n[CIN_BIT]        = sw_p1[WIDTH];
                        state_n               = VALID;
                        valid_n               = 1'b1;
                    end
                end
                VALID: begin
                    // op_bus is left intact so the LEDs keep the last operands.
                    if (op_valid && op_ready) begin
                        state_n = LOAD_A;
                        valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = LOAD_A;
                    valid_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_p0    <= '0;
            sw_p1    <= '0;
            state    <= LOAD_A;
            op_bus   <= '0;
            op_valid <= 1'b0;
        end else begin
            sw_p0    <= {sw_cin, sw_data};
            sw_p1    <= sw_p0;
            state    <= state_n;
            op_bus   <= bus_n;
            op_valid <= valid_n;
        end
    end

    assign state_led = state;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader with DEBOUNCE_CYCLES = 4; a queue of
// expected operand bundles is drained by a handshake monitor.
module tb_adder_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_data;
    logic       sw_cin;
    logic       key_enter;
    logic       key_clear;
    logic [8:0] op_bus;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] state_led;

    int vectors     = 0;
    int miscompares = 0;
    int press_cnt   = 0;

    logic [8:0] sb[$];

    adder_operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .sw_cin    (sw_cin),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .op_bus    (op_bus),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit with_clear);
        key_enter = 1'b1;
        key_clear = with_clear;
        tick(12);
        key_enter = 1'b0;
        key_clear = 1'b0;
        tick(12);
    endtask

    // Handshake monitor: every accepted transfer must match the next queued bundle.
    always @(negedge clk) begin
        if (!reset && op_valid && op_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: got %0h expected none", op_bus);
            end else begin
                logic [8:0] exp;
                exp = sb.pop_front();
                if (op_bus !== exp) begin
                    miscompares++;
                    $display("FAIL sb_transfer: got %0h expected %0h", op_bus, exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (dut.u_enter.key_press === 1'b1) press_cnt++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int changes;
        int n0;
        reset     = 1'b1;
        sw_data   = 4'h0;
        sw_cin    = 1'b0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        op_ready  = 1'b0;
        tick(2);
        check("rst_bus", op_bus, 9'h000);
        check("rst_valid", op_valid, 1'b0);
        check("rst_state", state_led, 2'b00);
        reset = 1'b0;
        tick(2);
        check("idle_state", state_led, 2'b00);

        // Basic A then B+cin entry and handshake
        sw_data = 4'h5;
        press(1'b0);
        check("t1_state_b", state_led, 2'b01);
        sw_data = 4'hA;
        sw_cin  = 1'b1;
        press(1'b0);
        check("t1_bus", op_bus, 9'h1A5);
        check("t1_valid", op_valid, 1'b1);
        check("t1_state_v", state_led, 2'b10);
        sb.push_back(9'h1A5);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        check("t1_hs_state", state_led, 2'b00);
        check("t1_hs_valid", op_valid, 1'b0);
        check("t1_hs_bus", op_bus, 9'h1A5);

        // Bouncing ENTER, then stable: one pulse, 7 cycles later
        sw_data = 4'h3;
        sw_cin  = 1'b0;
        n0 = press_cnt;
        for (int i = 0; i < 10; i++) begin
            key_enter = (i % 2 == 0);
            tick(2);
        end
        key_enter = 1'b1;
        tick(6);
        check("t2_no_early_pulse", dut.u_enter.key_press, 1'b0);
        tick(1);
        check("t2_pulse_at_7", dut.u_enter.key_press, 1'b1);
        tick(1);
        check("t2_pulse_one_cycle", dut.u_enter.key_press, 1'b0);
        tick(4);
        check("t2_pulse_count", press_cnt - n0, 1);
        check("t2_bus", op_bus, 9'h1A3);
        check("t2_state", state_led, 2'b01);
        key_enter = 1'b0;
        tick(12);

        sw_data = 4'h7;
        press(1'b0);
        check("t2b_bus", op_bus, 9'h073);
        check("t2b_valid", op_valid, 1'b1);

        // ENTER in VALID without ready is ignored
        sw_data = 4'hF;
        sw_cin  = 1'b1;
        press(1'b0);
        check("t3_bus", op_bus, 9'h073);
        check("t3_valid", op_valid, 1'b1);
        check("t3_state", state_led, 2'b10);

        // Switches toggling in VALID never disturb op_bus
        changes = 0;
        for (int i = 0; i < 16; i++) begin
            sw_data = 4'(i);
            sw_cin  = i[0];
            tick(1);
            if (op_bus !== 9'h073) changes++;
        end
        check("t6_bus_stable", changes, 0);
        sb.push_back(9'h073);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        check("t6_hs_state", state_led, 2'b00);

        // Capture while switches toggle: value driven after edge 5 of the press
        sw_cin    = 1'b0;
        key_enter = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sw_data = 4'((k * 5 + 2) & 15);
            tick(1);
        end
        key_enter = 1'b0;
        tick(12);
        check("t6_capture", op_bus, 9'h07B);
        check("t6_cap_state", state_led, 2'b01);

        // ENTER and CLEAR together in LOAD_B: clear wins
        sw_data = 4'hC;
        op_ready = 1'b1;
        press(1'b1);
        op_ready = 1'b0;
        check("t4_state", state_led, 2'b00);
        check("t4_bus", op_bus, 9'h000);
        check("t4_valid", op_valid, 1'b0);

        // Reset mid-debounce in LOAD_B
        sw_data = 4'h9;
        press(1'b0);
        check("t5_pre_state", state_led, 2'b01);
        check("t5_pre_bus", op_bus, 9'h009);
        n0 = press_cnt;
        key_enter = 1'b1;
        tick(3);
        #2;
        reset     = 1'b1;
        key_enter = 1'b0;
        #1;
        check("t5_async_bus", op_bus, 9'h000);
        check("t5_async_valid", op_valid, 1'b0);
        check("t5_async_state", state_led, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(15);
        check("t5_no_press", press_cnt - n0, 0);
        check("t5_state", state_led, 2'b00);
        check("t5_bus", op_bus, 9'h000);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
